// File: rtl/rob_pkg.sv
// Shared geometry, entry layout and pointer types for the N-way reorder buffer.
// All users import this package; the ROB geometry is configured here.
package rob_pkg;
    localparam int DEPTH      = 32;
    localparam int DISP_W     = 2;
    localparam int RET_W      = 2;
    localparam int CDB_W      = 2;
    localparam int PRF_IDX_W  = 6;
    localparam int ARCH_IDX_W = 5;
    localparam int BR_MASK_W  = 5;

    localparam int ROB_IDX_W  = $clog2(DEPTH);
    localparam int PTR_W      = ROB_IDX_W + 1;
    localparam int FL_W       = PRF_IDX_W - 1;
    localparam int RCNT_W     = $clog2(RET_W + 1);

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    // Extra MSB is the wrap bit, so full and empty are distinguishable.
    typedef logic [PTR_W-1:0]     rob_ptr_t;
    typedef logic [RCNT_W-1:0]    ret_cnt_t;

    typedef struct packed {
        logic [PRF_IDX_W-1:0]  dest_tag;
        logic [PRF_IDX_W-1:0]  old_tag;
        logic [ARCH_IDX_W-1:0] logic_dest;
        logic [63:0]           pc;
        logic                  br_flag;
        logic                  br_pretaken;
        logic                  br_taken;
        logic [BR_MASK_W-1:0]  br_mask;
        logic [FL_W-1:0]       fl_head;
    } rob_entry_t;

    function automatic rob_idx_t rob_dist(input rob_idx_t idx, input rob_idx_t head);
        return rob_idx_t'(idx - head);
    endfunction
endpackage

// File: rtl/rob_if.sv
// Dispatch / completion / retire / recovery bundle between the ROB and the core.
// slave = ROB side, master = core (dispatch, CDB, arch map) side.
interface rob_if;
    import rob_pkg::*;

    logic [DISP_W-1:0]                 disp_valid_i;
    logic [DISP_W-1:0][PRF_IDX_W-1:0]  disp_dest_tag_i;
    logic [DISP_W-1:0][PRF_IDX_W-1:0]  disp_old_tag_i;
    logic [DISP_W-1:0][ARCH_IDX_W-1:0] disp_logic_dest_i;
    logic [DISP_W-1:0][63:0]           disp_pc_i;
    logic [DISP_W-1:0]                 disp_br_flag_i;
    logic [DISP_W-1:0]                 disp_br_pretaken_i;
    logic [DISP_W-1:0][BR_MASK_W-1:0]  disp_br_mask_i;
    logic [DISP_W-1:0][FL_W-1:0]       disp_fl_head_i;
    logic                              disp_rdy_o;
    logic [DISP_W-1:0][ROB_IDX_W-1:0]  disp_idx_o;

    logic [CDB_W-1:0]                  cdb_valid_i;
    logic [CDB_W-1:0][ROB_IDX_W-1:0]   cdb_idx_i;
    logic [CDB_W-1:0]                  cdb_br_taken_i;

    logic [RET_W-1:0]                  ret_valid_o;
    logic [RET_W-1:0][PRF_IDX_W-1:0]   ret_dest_tag_o;
    logic [RET_W-1:0][PRF_IDX_W-1:0]   ret_old_tag_o;
    logic [RET_W-1:0][ARCH_IDX_W-1:0]  ret_logic_dest_o;

    logic                              recov_valid_o;
    logic [FL_W-1:0]                   recov_fl_head_o;
    logic [BR_MASK_W-1:0]              recov_br_mask_o;
    logic [PTR_W-1:0]                  count_o;

    modport slave (
        input  disp_valid_i, disp_dest_tag_i, disp_old_tag_i, disp_logic_dest_i, disp_pc_i,
               disp_br_flag_i, disp_br_pretaken_i, disp_br_mask_i, disp_fl_head_i,
               cdb_valid_i, cdb_idx_i, cdb_br_taken_i,
        output disp_rdy_o, disp_idx_o, ret_valid_o, ret_dest_tag_o, ret_old_tag_o,
               ret_logic_dest_o, recov_valid_o, recov_fl_head_o, recov_br_mask_o, count_o
    );

    modport master (
        output disp_valid_i, disp_dest_tag_i, disp_old_tag_i, disp_logic_dest_i, disp_pc_i,
               disp_br_flag_i, disp_br_pretaken_i, disp_br_mask_i, disp_fl_head_i,
               cdb_valid_i, cdb_idx_i, cdb_br_taken_i,
        input  disp_rdy_o, disp_idx_o, ret_valid_o, ret_dest_tag_o, ret_old_tag_o,
               ret_logic_dest_o, recov_valid_o, recov_fl_head_o, recov_br_mask_o, count_o
    );
endinterface

// File: rtl/rob_retire_sel.sv
// Picks the contiguous run of done entries starting at head, up to RET_W.
// Latency: combinational.
// Backpressure: none; limited only by occupancy and the done vector.
module rob_retire_sel
    import rob_pkg::*;
(
    input  logic [DEPTH-1:0] done_i,
    input  rob_idx_t         head_i,
    input  rob_ptr_t         count_i,
    output logic [RET_W-1:0] ret_valid_o,
    output ret_cnt_t         ret_cnt_o
);
    rob_idx_t idx;
    logic     run;

    always_comb begin
        ret_valid_o = '0;
        ret_cnt_o   = '0;
        run         = 1'b1;
        idx         = head_i;
        for (int k = 0; k < RET_W; k++) begin
            idx = rob_idx_t'(head_i + rob_idx_t'(k));
            run = run && done_i[idx] && (k < int'(count_i));
            ret_valid_o[k] = run;
            if (run) ret_cnt_o = ret_cnt_o + ret_cnt_t'(1);
        end
    end
endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: multi-slot dispatch, CDB completion, in-order retire, mispredict truncate.
// Latency: dispatch/completion take effect at the edge; retire and recovery outputs are combinational.
// Backpressure: disp_rdy_o low unless DISP_W free entries and no recovery. Optional: ROB_DEBUG_EN.
module rob_nway
    import rob_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    rob_if.slave     bus
`ifdef ROB_DEBUG_EN
    ,
    output rob_ptr_t         dbg_head_o,
    output rob_ptr_t         dbg_tail_o,
    output logic [DEPTH-1:0] dbg_done_o,
    output logic [31:0]      dbg_retired_cnt_o
`endif
);
    rob_ptr_t         head_q, head_d, tail_q, tail_d;
    rob_entry_t       entries_q [DEPTH];
    logic [DEPTH-1:0] done_q;

    rob_ptr_t   count;
    rob_idx_t   head_idx, tail_idx;
    rob_ptr_t   disp_n;
    logic       disp_rdy, disp_fire;
    rob_entry_t disp_ent [DISP_W];

    logic [RET_W-1:0] ret_vld;
    ret_cnt_t         ret_cnt;

    rob_idx_t [CDB_W-1:0] cdb_dist;
    logic     [CDB_W-1:0] mispred;
    logic                 recov_vld;
    rob_idx_t             sel_idx, sel_dist;
    rob_ptr_t             recov_tail;

    assign count    = rob_ptr_t'(tail_q - head_q);
    assign head_idx = head_q[ROB_IDX_W-1:0];
    assign tail_idx = tail_q[ROB_IDX_W-1:0];

    always_comb begin
        disp_n = '0;
        for (int k = 0; k < DISP_W; k++) begin
            disp_n = disp_n + rob_ptr_t'(bus.disp_valid_i[k]);
            disp_ent[k] = '{dest_tag:    bus.disp_dest_tag_i[k],
                            old_tag:     bus.disp_old_tag_i[k],
                            logic_dest:  bus.disp_logic_dest_i[k],
                            pc:          bus.disp_pc_i[k],
                            br_flag:     bus.disp_br_flag_i[k],
                            br_pretaken: bus.disp_br_pretaken_i[k],
                            br_taken:    1'b0,
                            br_mask:     bus.disp_br_mask_i[k],
                            fl_head:     bus.disp_fl_head_i[k]};
        end
    end

    assign disp_rdy  = ((DEPTH - int'(count)) >= DISP_W) && !recov_vld;
    assign disp_fire = disp_rdy && (disp_n != '0);

    // Oldest mispredicting port wins; distance from head orders ports by age.
    always_comb begin
        cdb_dist  = '0;
        mispred   = '0;
        recov_vld = 1'b0;
        sel_idx   = '0;
        sel_dist  = '1;
        for (int p = 0; p < CDB_W; p++) begin
            cdb_dist[p] = rob_dist(bus.cdb_idx_i[p], head_idx);
            mispred[p]  = bus.cdb_valid_i[p] && entries_q[bus.cdb_idx_i[p]].br_flag &&
                          (bus.cdb_br_taken_i[p] != entries_q[bus.cdb_idx_i[p]].br_pretaken);
            if (mispred[p] && (!recov_vld || (cdb_dist[p] < sel_dist))) begin
                recov_vld = 1'b1;
                sel_idx   = bus.cdb_idx_i[p];
                sel_dist  = cdb_dist[p];
            end
        end
    end

    assign recov_tail = rob_ptr_t'(head_q + rob_ptr_t'(sel_dist) + rob_ptr_t'(1));

    rob_retire_sel u_retire_sel (
        .done_i      (done_q),
        .head_i      (head_idx),
        .count_i     (count),
        .ret_valid_o (ret_vld),
        .ret_cnt_o   (ret_cnt)
    );

    always_comb begin
        head_d = rob_ptr_t'(head_q + rob_ptr_t'(ret_cnt));
        if (recov_vld)      tail_d = recov_tail;
        else if (disp_fire) tail_d = rob_ptr_t'(tail_q + disp_n);
        else                tail_d = tail_q;
    end

    always_comb begin
        bus.ret_valid_o      = ret_vld;
        bus.ret_dest_tag_o   = '0;
        bus.ret_old_tag_o    = '0;
        bus.ret_logic_dest_o = '0;
        for (int k = 0; k < RET_W; k++) begin
            if (ret_vld[k]) begin
                bus.ret_dest_tag_o[k]   = entries_q[rob_idx_t'(head_idx + rob_idx_t'(k))].dest_tag;
                bus.ret_old_tag_o[k]    = entries_q[rob_idx_t'(head_idx + rob_idx_t'(k))].old_tag;
                bus.ret_logic_dest_o[k] = entries_q[rob_idx_t'(head_idx + rob_idx_t'(k))].logic_dest;
            end
        end
        for (int k = 0; k < DISP_W; k++) begin
            bus.disp_idx_o[k] = rob_idx_t'(tail_idx + rob_idx_t'(k));
        end
    end

    assign bus.disp_rdy_o      = disp_rdy;
    assign bus.recov_valid_o   = recov_vld;
    assign bus.recov_fl_head_o = recov_vld ? entries_q[sel_idx].fl_head : '0;
    assign bus.recov_br_mask_o = recov_vld ? entries_q[sel_idx].br_mask : '0;
    assign bus.count_o         = count;

    // Later assignments override earlier ones: dispatch, retire clear, completion, squash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (disp_fire) begin
                for (int k = 0; k < DISP_W; k++) begin
                    if (bus.disp_valid_i[k]) begin
                        entries_q[rob_idx_t'(tail_idx + rob_idx_t'(k))] <= disp_ent[k];
                        done_q[rob_idx_t'(tail_idx + rob_idx_t'(k))]    <= 1'b0;
                    end
                end
            end
            for (int k = 0; k < RET_W; k++) begin
                if (ret_vld[k]) begin
                    done_q[rob_idx_t'(head_idx + rob_idx_t'(k))]            <= 1'b0;
                    entries_q[rob_idx_t'(head_idx + rob_idx_t'(k))].br_flag <= 1'b0;
                end
            end
            for (int p = 0; p < CDB_W; p++) begin
                if (bus.cdb_valid_i[p] && (!recov_vld || (cdb_dist[p] <= sel_dist))) begin
                    done_q[bus.cdb_idx_i[p]]             <= 1'b1;
                    entries_q[bus.cdb_idx_i[p]].br_taken <= bus.cdb_br_taken_i[p];
                end
            end
            if (recov_vld) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rob_dist(rob_idx_t'(i), head_idx) > sel_dist) done_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ROB_DEBUG_EN
    logic [31:0] retired_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt_q <= '0;
        else        retired_cnt_q <= retired_cnt_q + 32'(ret_cnt);
    end

    assign dbg_head_o        = head_q;
    assign dbg_tail_o        = tail_q;
    assign dbg_done_o        = done_q;
    assign dbg_retired_cnt_o = retired_cnt_q;
`endif
endmodule

// File: tb/tb_rob_nway.sv
// Scoreboarded bench for rob_nway: directed dispatch/complete/mispredict sequences,
// expected retire and recovery payloads queued at issue and checked by a monitor.
module tb_rob_nway;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_if bus ();

`ifdef ROB_DEBUG_EN
    rob_ptr_t         dbg_head, dbg_tail;
    logic [DEPTH-1:0] dbg_done;
    logic [31:0]      dbg_ret;
`endif

    rob_nway dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ROB_DEBUG_EN
        ,
        .dbg_head_o        (dbg_head),
        .dbg_tail_o        (dbg_tail),
        .dbg_done_o        (dbg_done),
        .dbg_retired_cnt_o (dbg_ret)
`endif
    );

    typedef struct {
        int         seq;
        logic [5:0] dest;
        logic [5:0] old;
        logic [4:0] ld;
    } exp_ret_t;

    typedef struct {
        logic [4:0] fl;
        logic [4:0] mask;
    } exp_rec_t;

    exp_ret_t exp_ret[$];
    exp_rec_t exp_rec[$];
    int tests = 0;
    int fails = 0;
    int seq_n = 0;
    int tail_m = 0;
    int seq_of [32];
    int ptr_of [32];

    function automatic logic [5:0]  f_dest(input int s); return 6'((s * 3 + 1) % 64); endfunction
    function automatic logic [5:0]  f_old (input int s); return 6'((s * 5 + 2) % 64); endfunction
    function automatic logic [4:0]  f_ld  (input int s); return 5'(s % 32); endfunction
    function automatic logic [4:0]  f_mask(input int s); return 5'((s % 31) + 1); endfunction
    function automatic logic [4:0]  f_fl  (input int s); return 5'((s * 7 + 3) % 32); endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.disp_valid_i       = '0;
        bus.disp_dest_tag_i    = '0;
        bus.disp_old_tag_i     = '0;
        bus.disp_logic_dest_i  = '0;
        bus.disp_pc_i          = '0;
        bus.disp_br_flag_i     = '0;
        bus.disp_br_pretaken_i = '0;
        bus.disp_br_mask_i     = '0;
        bus.disp_fl_head_i     = '0;
        bus.cdb_valid_i        = '0;
        bus.cdb_idx_i          = '0;
        bus.cdb_br_taken_i     = '0;
    endtask

    // One clock of stimulus; called and returns at posedge+1.
    task automatic cyc(input int dn, input logic [1:0] dbr, input logic [1:0] dpt,
                       input logic [1:0] cv, input int ci0, input int ci1, input logic [1:0] ct,
                       input bit exp_rdy, input int rec_idx);
        int s;
        exp_ret_t e;
        for (int k = 0; k < 2; k++) begin
            s = seq_n + k;
            bus.disp_valid_i[k]       = (k < dn);
            bus.disp_dest_tag_i[k]    = f_dest(s);
            bus.disp_old_tag_i[k]     = f_old(s);
            bus.disp_logic_dest_i[k]  = f_ld(s);
            bus.disp_pc_i[k]          = 64'(32'h1000 + s * 4);
            bus.disp_br_flag_i[k]     = dbr[k];
            bus.disp_br_pretaken_i[k] = dpt[k];
            bus.disp_br_mask_i[k]     = f_mask(s);
            bus.disp_fl_head_i[k]     = f_fl(s);
        end
        bus.cdb_valid_i    = cv;
        bus.cdb_idx_i[0]   = 5'(ci0);
        bus.cdb_idx_i[1]   = 5'(ci1);
        bus.cdb_br_taken_i = ct;
        if (rec_idx >= 0) begin
            exp_rec.push_back('{fl: f_fl(seq_of[rec_idx]), mask: f_mask(seq_of[rec_idx])});
            while (exp_ret.size() > 0 && exp_ret[$].seq > seq_of[rec_idx]) void'(exp_ret.pop_back());
        end
        @(negedge clk);
        check("disp_rdy", 64'(bus.disp_rdy_o), 64'(exp_rdy));
        check("disp_idx0", 64'(bus.disp_idx_o[0]), 64'(tail_m % 32));
        check("disp_idx1", 64'(bus.disp_idx_o[1]), 64'((tail_m + 1) % 32));
        check("recov_valid", 64'(bus.recov_valid_o), 64'(rec_idx >= 0));
        if (rec_idx >= 0) begin
            tail_m = (ptr_of[rec_idx] + 1) % 64;
        end else if (exp_rdy && dn > 0) begin
            for (int k = 0; k < dn; k++) begin
                s = seq_n + k;
                seq_of[(tail_m + k) % 32] = s;
                ptr_of[(tail_m + k) % 32] = (tail_m + k) % 64;
                e = '{seq: s, dest: f_dest(s), old: f_old(s), ld: f_ld(s)};
                exp_ret.push_back(e);
            end
            tail_m = (tail_m + dn) % 64;
            seq_n  = seq_n + dn;
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic idle(input bit rdy = 1'b1);
        cyc(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, rdy, -1);
    endtask

    task automatic disp(input int n, input logic [1:0] br = 2'b00, input logic [1:0] pt = 2'b00,
                        input bit rdy = 1'b1);
        cyc(n, br, pt, 2'b00, 0, 0, 2'b00, rdy, -1);
    endtask

    task automatic comp(input logic [1:0] cv, input int i0, input int i1, input bit rdy = 1'b1);
        cyc(0, 2'b00, 2'b00, cv, i0, i1, 2'b00, rdy, -1);
    endtask

    // Called at posedge+1, so no monitor sample races the queue flush.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        exp_ret.delete();
        exp_rec.delete();
        tail_m = 0;
        #1;
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_ret_valid", 64'(bus.ret_valid_o), 64'd0);
        check("rst_disp_rdy", 64'(bus.disp_rdy_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retire slot and recovery pulse is matched against the queued expectations.
    always @(negedge clk) begin
        exp_ret_t e;
        exp_rec_t r;
        if (rst_n) begin
            if (bus.ret_valid_o == 2'b10) begin
                tests++; fails++;
                $display("FAIL ret_contig: got 10 expected 01/11 at %0t", $time);
            end
            for (int k = 0; k < 2; k++) begin
                if (bus.ret_valid_o[k]) begin
                    if (exp_ret.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL ret_unexpected: slot %0d retired, nothing expected at %0t", k, $time);
                    end else begin
                        e = exp_ret.pop_front();
                        check("ret_dest_tag", 64'(bus.ret_dest_tag_o[k]), 64'(e.dest));
                        check("ret_old_tag", 64'(bus.ret_old_tag_o[k]), 64'(e.old));
                        check("ret_logic_dest", 64'(bus.ret_logic_dest_o[k]), 64'(e.ld));
                    end
                end
            end
            if (bus.recov_valid_o) begin
                if (exp_rec.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL recov_unexpected: recovery pulse with none expected at %0t", $time);
                end else begin
                    r = exp_rec.pop_front();
                    check("recov_fl_head", 64'(bus.recov_fl_head_o), 64'(r.fl));
                    check("recov_br_mask", 64'(bus.recov_br_mask_o), 64'(r.mask));
                end
            end
        end
    end

    initial begin
        drive_idle();
        #1;
        check("init_count", 64'(bus.count_o), 64'd0);
        check("init_disp_rdy", 64'(bus.disp_rdy_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset in the middle of a dispatch + completion cycle.
        disp(2);
        check("pre_rst_count", 64'(bus.count_o), 64'd2);
        bus.disp_valid_i = 2'b11;
        bus.cdb_valid_i  = 2'b11;
        bus.cdb_idx_i[0] = 5'd0;
        bus.cdb_idx_i[1] = 5'd1;
        #2;
        exp_ret.delete();
        tail_m = 0;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(bus.count_o), 64'd0);
        check("async_rst_ret", 64'(bus.ret_valid_o), 64'd0);
        check("async_rst_rdy", 64'(bus.disp_rdy_o), 64'd1);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        idle();
        check("post_rst_ret", 64'(bus.ret_valid_o), 64'd0);
        check("post_rst_count", 64'(bus.count_o), 64'd0);

        // Fill to DEPTH, then a blocked dispatch; retire still proceeds when full.
        do_reset();
        for (int i = 0; i < 16; i++) disp(2);
        check("full_count", 64'(bus.count_o), 64'd32);
        check("full_rdy", 64'(bus.disp_rdy_o), 64'd0);
        disp(2, 2'b00, 2'b00, 1'b0);
        check("full_count_hold", 64'(bus.count_o), 64'd32);
        comp(2'b11, 0, 1, 1'b0);
        check("full_ret_valid", 64'(bus.ret_valid_o), 64'd3);
        idle(1'b0);
        check("full_after_ret", 64'(bus.count_o), 64'd30);

        // Out-of-order completion, in-order retire.
        do_reset();
        disp(2);
        disp(1);
        comp(2'b11, 1, 2);
        check("ooo_ret_none", 64'(bus.ret_valid_o), 64'd0);
        comp(2'b01, 0, 0);
        check("ooo_ret_11", 64'(bus.ret_valid_o), 64'd3);
        idle();
        check("ooo_ret_01", 64'(bus.ret_valid_o), 64'd1);
        idle();
        check("ooo_ret_done", 64'(bus.ret_valid_o), 64'd0);
        check("ooo_count", 64'(bus.count_o), 64'd0);
        check("ooo_drained", 64'(exp_ret.size()), 64'd0);

        // Mispredict at idx 5; a completion to squashed idx 8 must be dropped.
        do_reset();
        disp(2);
        disp(2);
        disp(2, 2'b10, 2'b00);
        disp(2);
        disp(2);
        check("mp_count_pre", 64'(bus.count_o), 64'd10);
        cyc(2, 2'b00, 2'b00, 2'b11, 5, 8, 2'b01, 1'b0, 5);
        check("mp_count", 64'(bus.count_o), 64'd6);
        check("mp_tail", 64'(bus.disp_idx_o[0]), 64'd6);
        check("mp_no_ret", 64'(bus.ret_valid_o), 64'd0);
        comp(2'b11, 0, 1);
        comp(2'b11, 2, 3);
        comp(2'b01, 4, 0);
        idle();
        idle();
        check("mp_drain_count", 64'(bus.count_o), 64'd0);
        disp(2);
        disp(2);
        comp(2'b11, 6, 7);
        idle();
        idle();
        check("mp_squash_count", 64'(bus.count_o), 64'd2);
        check("mp_squash_ret", 64'(bus.ret_valid_o), 64'd0);
        check("mp_squash_left", 64'(exp_ret.size()), 64'd2);

        // Two mispredicts in one cycle with head=2: the older (idx 3) wins.
        do_reset();
        disp(2);
        disp(2, 2'b10, 2'b00);
        disp(2);
        disp(2, 2'b10, 2'b00);
        disp(2);
        comp(2'b11, 0, 1);
        idle();
        check("dual_count_pre", 64'(bus.count_o), 64'd8);
        cyc(0, 2'b00, 2'b00, 2'b11, 7, 3, 2'b11, 1'b0, 3);
        check("dual_count", 64'(bus.count_o), 64'd2);
        check("dual_tail", 64'(bus.disp_idx_o[0]), 64'd4);
        comp(2'b01, 2, 0);
        check("dual_ret", 64'(bus.ret_valid_o), 64'd3);
        idle();
        check("dual_count_end", 64'(bus.count_o), 64'd0);
        check("dual_drained", 64'(exp_ret.size()), 64'd0);

        // Advance head to 30, then dispatch across the wrap and retire 30,31,0,1.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(2, 2'b00, 2'b00, (i > 0) ? 2'b11 : 2'b00, 2 * i - 2, 2 * i - 1, 2'b00, 1'b1, -1);
        end
        comp(2'b11, 28, 29);
        idle();
        idle();
        check("wrap_empty", 64'(bus.count_o), 64'd0);
        disp(2);
        disp(2);
        check("wrap_count", 64'(bus.count_o), 64'd4);
        comp(2'b11, 1, 0);
        check("wrap_ret_none", 64'(bus.ret_valid_o), 64'd0);
        comp(2'b11, 31, 30);
        check("wrap_ret_hi", 64'(bus.ret_valid_o), 64'd3);
        idle();
        check("wrap_ret_lo", 64'(bus.ret_valid_o), 64'd3);
        idle();
        check("wrap_count_end", 64'(bus.count_o), 64'd0);
        check("wrap_drained", 64'(exp_ret.size()), 64'd0);

        check("recov_drained", 64'(exp_rec.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
